dmem_axil_bridge: RTL and testbench

- Data-side bus master directly downstream of the memory-access stage.
- Takes that stage's single-cycle-level load/store request (re/we, address, byte mask, lane-aligned store data) and converts it into one AXI4-Lite transaction.
- Returns the raw 64-bit read beat plus a one-cycle finish pulse. The memory stage holds its stall request until it sees this pulse.

---
 rtl/dmem_axil_bridge_pkg.sv | 21 ++
 rtl/dmem_axil_bridge.sv | 172 +++++++++++++++++
 tb/tb_dmem_axil_bridge.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_axil_bridge_pkg.sv
// Shared definitions for the data-side AXI4-Lite bridge: FSM encoding,
// AXI response codes and the word-alignment width.
package dmem_axil_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Requests are issued as whole 8-byte beats.
  localparam int ALIGN_W = 3;

endpackage

// File: rtl/dmem_axil_bridge.sv
// Turns one memory-stage load/store into one AXI4-Lite transaction and
// returns a one-cycle finish pulse. Optional handshake abort: DMEM_BUS_TIMEOUT_EN.
module dmem_axil_bridge
  import dmem_axil_bridge_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   wmask_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  finish_o,
  output logic                  err_o,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << ALIGN_W) - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_done, w_done;
  logic                err_q;

`ifdef DMEM_BUS_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting;
  logic             tmo_abort;

  assign waiting = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                   (state == S_WR_REQ)  || (state == S_WR_RESP);
`endif

  // Payload comes straight from registers so it is stable while valid is high.
  assign m_araddr = addr_q;
  assign m_awaddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign rdata_o  = rdata_q;
  assign err_o    = finish_o & err_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_n   = state;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    finish_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (re_i)      state_n = S_RD_ADDR;
        else if (we_i) state_n = S_WR_REQ;
      end
      S_RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) state_n = S_DONE;
      end
      S_WR_REQ: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        if ((aw_done || m_awready) && (w_done || m_wready)) state_n = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) state_n = S_DONE;
      end
      S_DONE: begin
        finish_o = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef DMEM_BUS_TIMEOUT_EN
    // Abort only on a cycle that makes no state progress.
    tmo_abort = waiting && (state_n == state) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    if (tmo_abort) state_n = S_DONE;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          err_q   <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (re_i) begin
            addr_q  <= addr_i & ALIGN_MASK;
          end else if (we_i) begin
            addr_q  <= addr_i & ALIGN_MASK;
            wdata_q <= wdata_i;
            wstrb_q <= wmask_i;
          end
        end
        S_RD_DATA: begin
          if (m_rvalid) begin
            rdata_q <= m_rdata;
            err_q   <= (m_rresp != RESP_OKAY);
          end
        end
        S_WR_REQ: begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
        S_WR_RESP: begin
          if (m_bvalid) err_q <= (m_bresp != RESP_OKAY);
        end
        default: ;
      endcase
`ifdef DMEM_BUS_TIMEOUT_EN
      if (tmo_abort) begin
        err_q <= 1'b1;
        if ((state == S_RD_ADDR) || (state == S_RD_DATA)) rdata_q <= '0;
      end
`endif
    end
  end

`ifdef DMEM_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                   tmo_cnt <= '0;
    else if (state_n != state) tmo_cnt <= '0;
    else if (waiting)          tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Self-checking bench for dmem_axil_bridge: a latency-programmable AXI4-Lite
// slave plus a byte-level reference memory that predicts every read.
module tb_dmem_axil_bridge;
  import dmem_axil_bridge_pkg::*;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_i, we_i;
  logic [63:0] addr_i;
  logic [7:0]  wmask_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        finish_o, err_o;
  logic        m_awvalid, m_awready;
  logic [63:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [63:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;

  always #5 clk = ~clk;

  dmem_axil_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
    .wmask_i(wmask_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .finish_o(finish_o), .err_o(err_o),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int checks = 0;
  int errors = 0;

  // Slave configuration and observations
  int          ar_lat, r_lat, aw_lat, w_lat, b_lat;
  logic [1:0]  cfg_rresp, cfg_bresp;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  logic [63:0] last_araddr, last_awaddr, last_wdata;
  logic [7:0]  last_wstrb;
  bit          aw_ever, w_alone;
  logic [63:0] slv_mem [0:7];

  // Reference model: plain byte array over the 64-byte test region
  logic [7:0]  ref_mem [0:63];

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] r;
    int base;
    base = int'(a[5:3]) * 8;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[base + k];
    return r;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [7:0] m, input logic [63:0] d);
    int base;
    base = int'(a[5:3]) * 8;
    for (int k = 0; k < 8; k++) if (m[k]) ref_mem[base + k] = d[8*k +: 8];
  endtask

  task automatic preload(input int idx, input logic [63:0] v);
    slv_mem[idx] = v;
    for (int k = 0; k < 8; k++) ref_mem[idx*8 + k] = v[8*k +: 8];
  endtask

  // ---------------- AXI4-Lite slave ----------------
  bit ar_fire, r_fire, aw_fire, w_fire, b_fire, aw_got, w_got, r_pend, b_pend;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

  task automatic slave_clear();
    m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
    ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
    aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
      end else begin
        if (m_awvalid) aw_ever = 1;
        if (m_wvalid && !m_awvalid) w_alone = 1;
        // retire handshakes completed at the previous edge
        if (ar_fire) begin ar_fire = 0; m_arready = 0; r_pend = 1; r_cnt = 0; end
        if (r_fire)  begin r_fire = 0; m_rvalid = 0; end
        if (aw_fire) begin aw_fire = 0; m_awready = 0; aw_got = 1; end
        if (w_fire)  begin w_fire = 0; m_wready = 0; w_got = 1; end
        if (b_fire)  begin b_fire = 0; m_bvalid = 0; end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          for (int k = 0; k < 8; k++)
            if (last_wstrb[k]) slv_mem[last_awaddr[5:3]][8*k +: 8] = last_wdata[8*k +: 8];
          b_pend = 1; b_cnt = 0;
        end
        // address / data acceptance after the programmed wait
        if (!m_arvalid) ar_cnt = 0;
        else if (!m_arready) begin
          if (ar_cnt >= ar_lat) begin m_arready = 1; ar_fire = 1; ar_hs++; last_araddr = m_araddr; end
          else ar_cnt++;
        end
        if (!m_awvalid) aw_cnt = 0;
        else if (!m_awready) begin
          if (aw_cnt >= aw_lat) begin m_awready = 1; aw_fire = 1; aw_hs++; last_awaddr = m_awaddr; end
          else aw_cnt++;
        end
        if (!m_wvalid) w_cnt = 0;
        else if (!m_wready) begin
          if (w_cnt >= w_lat) begin
            m_wready = 1; w_fire = 1; w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb;
          end else w_cnt++;
        end
        // responses
        if (r_pend && !m_rvalid) begin
          if (r_cnt >= r_lat) begin
            m_rvalid = 1; m_rdata = slv_mem[last_araddr[5:3]]; m_rresp = cfg_rresp;
          end else r_cnt++;
        end
        if (m_rvalid && m_rready && !r_fire) begin r_fire = 1; r_pend = 0; end
        if (b_pend && !m_bvalid) begin
          if (b_cnt >= b_lat) begin m_bvalid = 1; m_bresp = cfg_bresp; end
          else b_cnt++;
        end
        if (m_bvalid && m_bready && !b_fire) begin b_fire = 1; b_pend = 0; b_hs++; end
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic do_req(input bit re, input bit we, input logic [63:0] a,
                        input logic [7:0] m, input logic [63:0] d,
                        output int lat, output logic [63:0] rd, output logic er);
    @(negedge clk);
    re_i = re; we_i = we; addr_i = a; wmask_i = m; wdata_i = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!finish_o && lat < 2000);
    re_i = 0; we_i = 0;
    rd = rdata_o;
    er = err_o;
    checks++;
    if (finish_o !== 1'b1) begin
      errors++;
      $display("FAIL finish_wait: no finish_o within %0d cycles (addr %h)", lat, a);
    end
    @(posedge clk); #1;
    checks++;
    if (finish_o !== 1'b0) begin
      errors++;
      $display("FAIL finish_width: finish_o=%b one cycle later, required 0", finish_o);
    end
  endtask

  task automatic zero_lat();
    ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0;
    cfg_rresp = RESP_OKAY; cfg_bresp = RESP_OKAY;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, finish_o, err_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ar/aw/w/r/b/fin/err=%b required 0000000",
               {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, finish_o, err_o});
    end
    checks++;
    if (rdata_o !== 64'h0) begin errors++; $display("FAIL reset_rdata: %h required 0", rdata_o); end
    checks++;
    if ({m_araddr, m_awaddr} !== 128'h0) begin
      errors++; $display("FAIL reset_addr: ar %h aw %h required 0", m_araddr, m_awaddr);
    end
    checks++;
    if ({m_wdata, m_wstrb} !== 72'h0) begin
      errors++; $display("FAIL reset_wpay: wdata %h wstrb %h required 0", m_wdata, m_wstrb);
    end
    rst = 0;
  endtask

  task automatic test_read_zero_wait();
    int lat; logic [63:0] rd; logic er;
    zero_lat();
    preload(2, 64'h1122334455667788);
    do_req(1, 0, 64'h8000_0013, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (last_araddr !== 64'h8000_0010) begin errors++; $display("FAIL rd0_araddr: %h required 8000_0010", last_araddr); end
    checks++;
    if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL rd0_data: %h required 1122334455667788", rd); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd0_latency: %0d required 3", lat); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL rd0_err: %b required 0", er); end
  endtask

  task automatic test_store_backpressure();
    int lat; logic [63:0] rd; logic er; int b0;
    zero_lat();
    aw_lat = 2; w_lat = 5;
    w_alone = 0; b0 = b_hs;
    do_req(0, 1, 64'h8000_0024, 8'h0C, 64'h0000_0000_ABCD_0000, lat, rd, er);
    ref_write(64'h8000_0024, 8'h0C, 64'h0000_0000_ABCD_0000);
    checks++;
    if (w_alone !== 1'b1) begin errors++; $display("FAIL st_aw_first: wvalid-alone seen=%b required 1", w_alone); end
    checks++;
    if (last_awaddr !== 64'h8000_0020) begin errors++; $display("FAIL st_awaddr: %h required 8000_0020", last_awaddr); end
    checks++;
    if (last_wstrb !== 8'h0C || last_wdata !== 64'h0000_0000_ABCD_0000) begin
      errors++; $display("FAIL st_wpay: strb %h data %h required 0c 00000000abcd0000", last_wstrb, last_wdata);
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL st_latency: %0d required 8", lat); end
    checks++;
    if (b_hs - b0 !== 1) begin errors++; $display("FAIL st_bcount: %0d required 1", b_hs - b0); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL st_err: %b required 0", er); end
    zero_lat();
    do_req(1, 0, 64'h8000_0020, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (rd !== ref_read(64'h8000_0020)) begin errors++; $display("FAIL st_readback: %h required %h", rd, ref_read(64'h8000_0020)); end
  endtask

  task automatic test_simultaneous();
    int lat; logic [63:0] rd; logic er; int ar0, w0;
    zero_lat();
    aw_ever = 0; ar0 = ar_hs; w0 = w_hs;
    do_req(1, 1, 64'h8000_000A, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, lat, rd, er);
    checks++;
    if (ar_hs - ar0 !== 1 || w_hs - w0 !== 0 || aw_ever !== 1'b0) begin
      errors++; $display("FAIL both_read_wins: ar %0d w %0d awvalid_seen %b required 1 0 0", ar_hs - ar0, w_hs - w0, aw_ever);
    end
    checks++;
    if (rd !== ref_read(64'h8000_0008)) begin errors++; $display("FAIL both_data: %h required %h", rd, ref_read(64'h8000_0008)); end
  endtask

  task automatic test_error_resp();
    int lat; logic [63:0] rd; logic er;
    zero_lat();
    cfg_rresp = RESP_SLVERR;
    do_req(1, 0, 64'h8000_0018, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL rresp_err: %b required 1", er); end
    cfg_rresp = RESP_OKAY;
    do_req(1, 0, 64'h8000_0018, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL rresp_clear: %b required 0", er); end
    cfg_bresp = RESP_DECERR;
    do_req(0, 1, 64'h8000_0038, 8'h00, 64'h1234, lat, rd, er);
    checks++;
    if (er !== 1'b1 || last_wstrb !== 8'h00) begin
      errors++; $display("FAIL bresp_err: err %b strb %h required 1 00", er, last_wstrb);
    end
    cfg_bresp = RESP_OKAY;
  endtask

  task automatic test_reset_mid();
    int lat, n; logic [63:0] rd; logic er;
    zero_lat();
    r_lat = 20;
    @(negedge clk);
    re_i = 1; addr_i = 64'h8000_0030;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!m_rready && n < 50);
    checks++;
    if (m_rready !== 1'b1) begin errors++; $display("FAIL mid_reach_rdata: rready %b required 1", m_rready); end
    rst = 1; re_i = 0;
    @(posedge clk); #1;
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, finish_o, err_o} !== 7'b0 || rdata_o !== 64'h0) begin
      errors++; $display("FAIL mid_reset_outs: ctrl %b rdata %h required 0 0",
        {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, finish_o, err_o}, rdata_o);
    end
    rst = 0;
    r_lat = 0;
    do_req(1, 0, 64'h8000_0030, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (rd !== ref_read(64'h8000_0030) || lat !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL mid_fresh_read: data %h lat %0d err %b required %h 3 0", rd, lat, er, ref_read(64'h8000_0030));
    end
  endtask

`ifdef DMEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [63:0] rd; logic er;
    zero_lat();
    ar_lat = 100000;
    do_req(1, 0, 64'h8000_0000, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 64'h0 || lat !== TMO + 1) begin
      errors++; $display("FAIL timeout_abort: err %b rdata %h lat %0d required 1 0 %0d", er, rd, lat, TMO + 1);
    end
    checks++;
    if (m_arvalid !== 1'b0) begin errors++; $display("FAIL timeout_arvalid: %b required 0", m_arvalid); end
    zero_lat();
  endtask
`else
  task automatic test_no_timeout();
    int lat; logic [63:0] rd; logic er;
    zero_lat();
    ar_lat = 300;
    do_req(1, 0, 64'h8000_0000, 8'h00, 64'h0, lat, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== ref_read(64'h8000_0000) || lat !== 303) begin
      errors++; $display("FAIL long_wait: err %b rdata %h lat %0d required 0 %h 303", er, rd, lat, ref_read(64'h8000_0000));
    end
    zero_lat();
  endtask
`endif

  task automatic test_random();
    int lat, kind, aw0, exp_lat; logic [63:0] rd, a, d, exp_rd; logic er; logic [7:0] m;
    for (int i = 0; i < 40; i++) begin
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      cfg_rresp = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
      cfg_bresp = ($urandom_range(0, 3) == 0) ? RESP_DECERR : RESP_OKAY;
      kind = $urandom_range(0, 9);
      a = 64'h8000_0000 | 64'($urandom_range(0, 63));
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      aw0 = aw_hs;
      if (kind < 5) begin
        exp_rd = ref_read(a);
        exp_lat = 3 + ar_lat + r_lat;
        do_req(1, (kind == 0), a, m, d, lat, rd, er);
        checks++;
        if (rd !== exp_rd || er !== (cfg_rresp != RESP_OKAY) || lat !== exp_lat ||
            last_araddr !== {a[63:3], 3'b000} || aw_hs !== aw0) begin
          errors++;
          $display("FAIL rand_read[%0d]: data %h err %b lat %0d araddr %h aw %0d required %h %b %0d %h 0",
                   i, rd, er, lat, last_araddr, aw_hs - aw0, exp_rd, cfg_rresp != RESP_OKAY, exp_lat, {a[63:3], 3'b000});
        end
      end else begin
        exp_lat = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
        do_req(0, 1, a, m, d, lat, rd, er);
        ref_write(a, m, d);
        checks++;
        if (last_awaddr !== {a[63:3], 3'b000} || last_wdata !== d || last_wstrb !== m ||
            er !== (cfg_bresp != RESP_OKAY) || lat !== exp_lat) begin
          errors++;
          $display("FAIL rand_write[%0d]: awaddr %h wdata %h strb %h err %b lat %0d required %h %h %h %b %0d",
                   i, last_awaddr, last_wdata, last_wstrb, er, lat, {a[63:3], 3'b000}, d, m, cfg_bresp != RESP_OKAY, exp_lat);
        end
      end
    end
    zero_lat();
  endtask

  initial begin
    rst = 1; re_i = 0; we_i = 0; addr_i = '0; wmask_i = '0; wdata_i = '0;
    zero_lat();
    for (int i = 0; i < 8; i++) preload(i, {$urandom, $urandom});
    test_reset();
    test_read_zero_wait();
    test_store_backpressure();
    test_simultaneous();
    test_error_resp();
    test_reset_mid();
`ifdef DMEM_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
